// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on flush or hazard, stall hold, and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16,
  parameter int CTRL_W  = 7 + ALUOP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [CTRL_W-1:0]   id_ctrl,
  input  logic [3*REG_W-1:0]  id_regs,
  input  logic [5:0]          id_funct,
  input  logic [4*DATA_W-1:0] id_data,
  output logic                ex_valid,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [3*REG_W-1:0]  ex_regs,
  output logic [5:0]          ex_funct,
  output logic [4*DATA_W-1:0] ex_data,
  output logic                load_use,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam int MEM_READ_BIT = 3;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rt;
  logic             insert_bubble;

  // Register fields are packed {rs, rt, rd} with rs in the MSBs.
  assign id_rs = id_regs[2*REG_W +: REG_W];
  assign id_rt = id_regs[REG_W +: REG_W];
  assign ex_rt = ex_regs[REG_W +: REG_W];

  assign load_use = ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rt != '0) && id_valid &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // A stall freezes the hazard in place; only flush overrides a stall.
  assign insert_bubble = flush || (!stall && load_use);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_regs    <= '0;
      ex_funct   <= '0;
      ex_data    <= '0;
      bubble_cnt <= '0;
    end else if (insert_bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_regs  <= id_regs;
      ex_funct <= id_funct;
      ex_data  <= id_data;
      if (bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (!stall) begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_regs  <= id_regs;
      ex_funct <= id_funct;
      ex_data  <= id_data;
    end
  end

endmodule
